ccff_bitstream_loader: RTL and testbench

Upstream configuration stage for the FPGA fabric. It accepts the fabric bitstream as a byte stream over a valid/ready handshake and serialises it onto the fabric's configuration chain. It generates the chain clock (`prog_clk`), data (`ccff_head`) and a pre-load clear pulse (`set`), so the fabric can be programmed from a few package pins without external timing.

---
 rtl/ccff_bitstream_loader.sv | 241 ++++++++++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
//
// Configuration front end for the FPGA fabric. Bitstream bytes arrive over a
// valid/ready handshake and are serialised MSB first onto the fabric's
// configuration chain. The block generates the chain clock, the chain data
// and the pre-load clear pulse. Only the first CHAIN_LEN bits are shifted.
// The low bits of the final byte are padding and are dropped.
//
// Optional feature (macro CCFF_LOADER_CRC_EN):
//   When defined, a CRC-8 (poly 0x07, init 0x00, MSB first) is accumulated
//   over the shifted bits. One extra byte is accepted after the last bit and
//   compared against it. crc_err reports the result. When undefined, crc_err
//   is tied low.
//
// Parameters:
//   CHAIN_LEN  - configuration bits in the chain (>= 1)
//   PROG_DIV   - clk cycles per prog_clk phase (>= 1)
//   SET_CYCLES - clk cycles that set is held before loading (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   begin a load (honoured in IDLE and DONE only)
//   in_data    in   bitstream byte, MSB shifted first
//   in_valid   in   in_data valid
//   in_ready   out  byte accepted this cycle when in_valid is high
//   prog_clk   out  configuration chain clock (registered)
//   ccff_head  out  configuration chain serial data (registered)
//   set        out  configuration clear pulse
//   busy       out  load in progress (not IDLE and not DONE)
//   cfg_done   out  load finished, held until the next start
//   crc_err    out  integrity failure, meaningful while cfg_done is high
// ---------------------------------------------------------------------------
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN  = 1024,
    parameter int PROG_DIV   = 2,
    parameter int SET_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       prog_clk,
    output logic       ccff_head,
    output logic       set,
    output logic       busy,
    output logic       cfg_done,
    output logic       crc_err
);

    localparam int BIT_CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int CNT_MAX   = (PROG_DIV > SET_CYCLES) ? PROG_DIV : SET_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
`ifdef CCFF_LOADER_CRC_EN
        CRC,
`endif
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       phase_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [2:0]             bit_idx;
    logic [6:0]             shift_reg;
    logic                   phase_last;
    logic                   clear_last;
    logic                   chain_last;

    assign phase_last = (phase_cnt == CNT_W'(PROG_DIV - 1));
    assign clear_last = (phase_cnt == CNT_W'(SET_CYCLES - 1));
    assign chain_last = (bit_cnt == BIT_CNT_W'(CHAIN_LEN - 1));

`ifdef CCFF_LOADER_CRC_EN
    logic [7:0] crc;

    // One step of a non-reflected CRC-8 with polynomial x^8+x^2+x+1.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    // State register. Reset always lands in IDLE so every
    // state-decoded output drops to zero in the cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded outputs. SHIFT_HI decides where
    // to go once its phase ends. It stops at the chain length first, so
    // padding bits in the last byte never reach the chain.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        set        = 1'b0;
        busy       = 1'b1;
        cfg_done   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                set = 1'b1;
                if (clear_last) state_next = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (phase_last) state_next = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (phase_last) begin
                    if (chain_last) begin
`ifdef CCFF_LOADER_CRC_EN
                        state_next = CRC;
`else
                        state_next = DONE;
`endif
                    end else if (bit_idx == 3'd7) begin
                        state_next = LOAD;
                    end else begin
                        state_next = SHIFT_LO;
                    end
                end
            end
`ifdef CCFF_LOADER_CRC_EN
            CRC: begin
                in_ready = 1'b1;
                if (in_valid) state_next = DONE;
            end
`endif
            DONE: begin
                busy     = 1'b0;
                cfg_done = 1'b1;
                if (start) state_next = CLEAR;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Shared phase timer for the CLEAR hold and both prog_clk phases. It
    // restarts on every state change, so each state counts from zero. In the
    // states that don't time anything it runs freely and is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_cnt <= '0;
        end else if (state_next != state) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
        end
    end

    // Serialiser datapath. A byte's MSB goes straight to ccff_head and the
    // remaining seven bits wait in shift_reg. ccff_head only advances after
    // a prog_clk high phase, and only if another bit of this byte will be
    // shifted. This keeps the last chain bit on ccff_head through DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_clk  <= 1'b0;
            ccff_head <= 1'b0;
            shift_reg <= '0;
            bit_idx   <= '0;
            bit_cnt   <= '0;
`ifdef CCFF_LOADER_CRC_EN
            crc       <= '0;
            crc_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bit_cnt <= '0;
`ifdef CCFF_LOADER_CRC_EN
                        crc     <= '0;
                        crc_err <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        ccff_head <= in_data[7];
                        shift_reg <= in_data[6:0];
                        bit_idx   <= '0;
                    end
                end
                SHIFT_LO: begin
                    if (phase_last) prog_clk <= 1'b1;
                end
                SHIFT_HI: begin
                    if (phase_last) begin
                        prog_clk  <= 1'b0;
                        bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                        bit_idx   <= bit_idx + 3'd1;
                        shift_reg <= {shift_reg[5:0], 1'b0};
`ifdef CCFF_LOADER_CRC_EN
                        crc       <= crc8_step(crc, ccff_head);
`endif
                        if (!chain_last && (bit_idx != 3'd7)) begin
                            ccff_head <= shift_reg[6];
                        end
                    end
                end
`ifdef CCFF_LOADER_CRC_EN
                CRC: begin
                    if (in_valid) crc_err <= (in_data != crc);
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifndef CCFF_LOADER_CRC_EN
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_bitstream_loader
//
// Self-checking bench for ccff_bitstream_loader with CHAIN_LEN=12,
// PROG_DIV=2 and SET_CYCLES=4. A table of loads (byte pair, source stall,
// start-while-busy poke, expected rise/set counts) is applied in a loop.
// The expected chain bits are queued when the bytes are chosen. A monitor
// pops one entry at every prog_clk rise and compares it with ccff_head.
// Hand-written sequences cover the reset state, a reset in the middle of a
// load, and, when CCFF_LOADER_CRC_EN is defined, the CRC check on a second
// 8-bit instance.
// ---------------------------------------------------------------------------
module tb_ccff_bitstream_loader;

    localparam int CHAIN_LEN  = 12;
    localparam int PROG_DIV   = 2;
    localparam int SET_CYCLES = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       prog_clk;
    logic       ccff_head;
    logic       set;
    logic       busy;
    logic       cfg_done;
    logic       crc_err;

    always #5 clk = ~clk;

    ccff_bitstream_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .PROG_DIV  (PROG_DIV),
        .SET_CYCLES(SET_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .prog_clk (prog_clk),
        .ccff_head(ccff_head),
        .set      (set),
        .busy     (busy),
        .cfg_done (cfg_done),
        .crc_err  (crc_err)
    );

`ifdef CCFF_LOADER_CRC_EN
    logic       c_start;
    logic [7:0] c_in_data;
    logic       c_in_valid;
    logic       c_in_ready;
    logic       c_prog_clk;
    logic       c_ccff_head;
    logic       c_set;
    logic       c_busy;
    logic       c_cfg_done;
    logic       c_crc_err;

    ccff_bitstream_loader #(
        .CHAIN_LEN (8),
        .PROG_DIV  (PROG_DIV),
        .SET_CYCLES(SET_CYCLES)
    ) crc_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (c_start),
        .in_data  (c_in_data),
        .in_valid (c_in_valid),
        .in_ready (c_in_ready),
        .prog_clk (c_prog_clk),
        .ccff_head(c_ccff_head),
        .set      (c_set),
        .busy     (c_busy),
        .cfg_done (c_cfg_done),
        .crc_err  (c_crc_err)
    );
`endif

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         stall;
        bit         poke;
        int         exp_rises;
        int         exp_sets;
        logic       exp_done;
    } vec_t;

    vec_t       vecs[6];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         rise_cnt = 0;
    int         set_cnt = 0;
    logic       prev_pclk = 1'b0;
    logic       exp_q[$];
    logic [7:0] model_crc;
    logic       last_bit;

    // Reference CRC-8: poly 0x07, init 0, MSB first.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Queue the bits the chain should see and fold them into the CRC model.
    task automatic pushBits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            exp_q.push_back(b[7-i]);
            model_crc = crc_step(model_crc, b[7-i]);
            last_bit  = b[7-i];
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (in_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) checkOutput("timeout_in_ready", 0, 1);
    endtask

    task automatic waitDone();
        int n = 0;
        while (cfg_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (cfg_done !== 1'b1) checkOutput("timeout_cfg_done", 0, 1);
    endtask

    // Scoreboard monitor. It samples 2 time units after each rising edge,
    // counts set cycles and prog_clk rises, and checks every rise against
    // the head of the expected-bit queue.
    always begin
        @(posedge clk);
        #2;
        if (set === 1'b1) set_cnt++;
        if (prog_clk === 1'b1 && prev_pclk === 1'b0) begin
            rise_cnt++;
            if (exp_q.size() == 0) begin
                checkOutput("extra_prog_clk_rise", 1, 0);
            end else begin
                checkOutput("ccff_head_at_rise", ccff_head, exp_q.pop_front());
            end
        end
        prev_pclk = prog_clk;
    end

    // One complete load. The first byte is presented with in_valid high from
    // the start cycle onwards, so it must not transfer before LOAD.
    task automatic applyStimulus(input vec_t v);
        exp_q.delete();
        model_crc = 8'h00;
        rise_cnt  = 0;
        set_cnt   = 0;
        pushBits(v.b0, 8);
        pushBits(v.b1, CHAIN_LEN - 8);

        @(negedge clk);
        start    = 1'b1;
        in_data  = v.b0;
        in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_clears_cfg_done", cfg_done, 0);
        checkOutput("busy_after_start", busy, 1);
        checkOutput("start_clears_crc_err", crc_err, 0);

        waitReady();
        @(negedge clk);
        in_data = v.b1;
        if (v.stall > 0) in_valid = 1'b0;

        if (v.poke) begin
            int n = 0;
            while (prog_clk !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            checkOutput("poke_in_shift_hi", prog_clk, 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end

        if (v.stall > 0) begin
            waitReady();
            for (int i = 0; i < v.stall; i++) begin
                checkOutput("gap_prog_clk_low", prog_clk, 0);
                checkOutput("gap_in_ready", in_ready, 1);
                @(negedge clk);
            end
            in_valid = 1'b1;
        end

        waitReady();
        @(negedge clk);
        in_valid = 1'b0;

`ifdef CCFF_LOADER_CRC_EN
        in_data  = model_crc;
        in_valid = 1'b1;
        waitReady();
        @(negedge clk);
        in_valid = 1'b0;
`endif

        waitDone();
        checkOutput("rise_count", rise_cnt, v.exp_rises);
        checkOutput("set_cycles", set_cnt, v.exp_sets);
        checkOutput("cfg_done", cfg_done, v.exp_done);
        checkOutput("busy_in_done", busy, 0);
        checkOutput("prog_clk_in_done", prog_clk, 0);
        checkOutput("ccff_head_holds_last", ccff_head, last_bit);
        checkOutput("bits_left_unshifted", exp_q.size(), 0);
        checkOutput("crc_err_in_done", crc_err, 0);
    endtask

`ifdef CCFF_LOADER_CRC_EN
    task automatic cSend(input logic [7:0] b);
        int n = 0;
        while (c_in_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (c_in_ready !== 1'b1) checkOutput("timeout_crc_in_ready", 0, 1);
        c_in_data  = b;
        c_in_valid = 1'b1;
        @(negedge clk);
        c_in_valid = 1'b0;
    endtask

    task automatic crcLoad(input logic [7:0] payload, input logic [7:0] crc_byte,
                           input logic exp_err);
        int n = 0;
        @(negedge clk);
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        checkOutput("crc_start_clears_done", c_cfg_done, 0);
        checkOutput("crc_start_clears_err", c_crc_err, 0);
        cSend(payload);
        cSend(crc_byte);
        while (c_cfg_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("crc_cfg_done", c_cfg_done, 1);
        checkOutput("crc_err_flag", c_crc_err, exp_err);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] good_crc;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
`ifdef CCFF_LOADER_CRC_EN
        c_start    = 1'b0;
        c_in_valid = 1'b0;
        c_in_data  = 8'h00;
`endif

        vecs[0] = '{b0: 8'hA5, b1: 8'h3F, stall: 0,  poke: 1'b0, exp_rises: 12, exp_sets: 4, exp_done: 1'b1};
        vecs[1] = '{b0: 8'hA5, b1: 8'h3F, stall: 10, poke: 1'b0, exp_rises: 12, exp_sets: 4, exp_done: 1'b1};
        vecs[2] = '{b0: 8'hA5, b1: 8'h3F, stall: 0,  poke: 1'b1, exp_rises: 12, exp_sets: 4, exp_done: 1'b1};
        vecs[3] = '{b0: 8'h5A, b1: 8'hC7, stall: 3,  poke: 1'b0, exp_rises: 12, exp_sets: 4, exp_done: 1'b1};
        vecs[4] = '{b0: 8'hFF, b1: 8'hF0, stall: 0,  poke: 1'b0, exp_rises: 12, exp_sets: 4, exp_done: 1'b1};
        vecs[5] = '{b0: 8'h00, b1: 8'h0F, stall: 0,  poke: 1'b1, exp_rises: 12, exp_sets: 4, exp_done: 1'b1};

        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_prog_clk", prog_clk, 0);
        checkOutput("reset_ccff_head", ccff_head, 0);
        checkOutput("reset_set", set, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_cfg_done", cfg_done, 0);
        checkOutput("reset_crc_err", crc_err, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            $display("[TB] load vector %0d: %02h %02h stall=%0d poke=%0d",
                     i, vecs[i].b0, vecs[i].b1, vecs[i].stall, vecs[i].poke);
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of the first byte, then a clean reload.
        $display("[TB] mid-load reset");
        begin
            int n = 0;
            exp_q.delete();
            model_crc = 8'h00;
            rise_cnt  = 0;
            pushBits(8'hA5, 8);
            @(negedge clk);
            start    = 1'b1;
            in_data  = 8'hA5;
            in_valid = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (rise_cnt < 5 && n < 400) begin
                @(negedge clk);
                n++;
            end
            checkOutput("rises_before_reset", rise_cnt, 5);
            reset    = 1'b1;
            in_valid = 1'b0;
            @(negedge clk);
            checkOutput("midreset_in_ready", in_ready, 0);
            checkOutput("midreset_prog_clk", prog_clk, 0);
            checkOutput("midreset_ccff_head", ccff_head, 0);
            checkOutput("midreset_set", set, 0);
            checkOutput("midreset_busy", busy, 0);
            checkOutput("midreset_cfg_done", cfg_done, 0);
            checkOutput("midreset_crc_err", crc_err, 0);
            reset = 1'b0;
            exp_q.delete();
            @(negedge clk);
            checkOutput("rises_after_reset", rise_cnt, 5);
        end
        applyStimulus(vecs[0]);

`ifdef CCFF_LOADER_CRC_EN
        $display("[TB] crc checks");
        good_crc = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] payload;
            payload  = 8'h01;
            good_crc = crc_step(good_crc, payload[i]);
        end
        crcLoad(8'h01, good_crc, 1'b0);
        crcLoad(8'h01, good_crc ^ 8'h01, 1'b1);
        crcLoad(8'h01, good_crc, 1'b0);
`else
        good_crc = 8'h00;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
